// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch sequencer
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_HALT
  } state_t;

  // Ascending priority, so "higher priority" is a plain numeric compare.
  typedef enum logic [2:0] {
    RK_NONE = 3'd0,
    RK_JMP  = 3'd1,
    RK_BR   = 3'd2,
    RK_HALT = 3'd3,
    RK_EXC  = 3'd4
  } kind_t;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/fetch_ctrl_redirect_sel.sv
// rtl/fetch_ctrl_redirect_sel.sv - picks the highest-priority redirect request this cycle
module redirect_sel
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  output kind_t       kind,
  output logic [31:0] target
);

  always_comb begin
    kind   = RK_NONE;
    target = '0;
    if (exc) begin
      kind   = RK_EXC;
      target = EXC_VECTOR;
    end else if (halt) begin
      kind = RK_HALT;
    end else if (br_taken) begin
      kind   = RK_BR;
      target = br_target;
    end else if (jmp && !stall) begin
      // A stalled jump is not a request yet; ID presents it again.
      kind   = RK_JMP;
      target = jmp_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: boot delay, redirect arbitration, freeze hold, halt
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_FetchCtrl_stall,
  input  logic        i_FetchCtrl_freeze,
  input  logic        i_FetchCtrl_exc,
  input  logic        i_FetchCtrl_halt,
  input  logic        i_FetchCtrl_br_taken,
  input  logic [31:0] i_FetchCtrl_br_target,
  input  logic        i_FetchCtrl_jmp,
  input  logic [31:0] i_FetchCtrl_jmp_target,
  output logic        o_FetchCtrl_pause,
  output logic        o_FetchCtrl_we,
  output logic [31:0] o_FetchCtrl_PC,
  output logic        o_FetchCtrl_flush_if,
  output logic        o_FetchCtrl_flush_id,
  output logic        o_FetchCtrl_halted
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

  state_t        state;
  logic [CW-1:0] boot_cnt;
  kind_t         pend_kind;
  logic [31:0]   pend_target;
  kind_t         sel_kind;
  logic [31:0]   sel_target;
  kind_t         apply_kind;
  logic [31:0]   apply_target;

  redirect_sel #(.EXC_VECTOR(EXC_VECTOR)) u_sel (
    .exc        (i_FetchCtrl_exc),
    .halt       (i_FetchCtrl_halt),
    .br_taken   (i_FetchCtrl_br_taken),
    .br_target  (i_FetchCtrl_br_target),
    .jmp        (i_FetchCtrl_jmp),
    .jmp_target (i_FetchCtrl_jmp_target),
    .stall      (i_FetchCtrl_stall),
    .kind       (sel_kind),
    .target     (sel_target)
  );

  // In HOLD the pending request wins unless a strictly higher one arrives.
  always_comb begin
    apply_kind   = sel_kind;
    apply_target = sel_target;
    if (state == ST_HOLD && !(sel_kind > pend_kind)) begin
      apply_kind   = pend_kind;
      apply_target = pend_target;
    end
  end

  always_comb begin
    o_FetchCtrl_pause    = 1'b1;
    o_FetchCtrl_we       = 1'b0;
    o_FetchCtrl_PC       = '0;
    o_FetchCtrl_flush_if = 1'b0;
    o_FetchCtrl_flush_id = 1'b0;
    o_FetchCtrl_halted   = (state == ST_HALT);
    if ((state == ST_RUN || state == ST_HOLD) && !i_FetchCtrl_freeze) begin
      case (apply_kind)
        RK_EXC, RK_BR: begin
          o_FetchCtrl_pause    = 1'b0;
          o_FetchCtrl_we       = 1'b1;
          o_FetchCtrl_PC       = apply_target;
          o_FetchCtrl_flush_if = 1'b1;
          o_FetchCtrl_flush_id = 1'b1;
        end
        RK_JMP: begin
          o_FetchCtrl_pause    = 1'b0;
          o_FetchCtrl_we       = 1'b1;
          o_FetchCtrl_PC       = apply_target;
          o_FetchCtrl_flush_if = 1'b1;
        end
        RK_HALT: o_FetchCtrl_flush_if = 1'b1;
        default: o_FetchCtrl_pause = i_FetchCtrl_stall;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_BOOT;
      boot_cnt    <= CW'(BOOT_CYCLES);
      pend_kind   <= RK_NONE;
      pend_target <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt <= CW'(1)) state <= ST_RUN;
          else boot_cnt <= boot_cnt - CW'(1);
        end
        ST_RUN: begin
          if (i_FetchCtrl_freeze) begin
            if (sel_kind != RK_NONE) begin
              pend_kind   <= sel_kind;
              pend_target <= sel_target;
              state       <= ST_HOLD;
            end
          end else if (sel_kind == RK_HALT) begin
            state <= ST_HALT;
          end
        end
        ST_HOLD: begin
          if (i_FetchCtrl_freeze) begin
            if (sel_kind > pend_kind) begin
              pend_kind   <= sel_kind;
              pend_target <= sel_target;
            end
          end else begin
            pend_kind   <= RK_NONE;
            pend_target <= '0;
            state       <= (apply_kind == RK_HALT) ? ST_HALT : ST_RUN;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

  localparam int unsigned BOOT_CYCLES = 2;
  localparam logic [31:0] EXC_VEC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0, freeze = 1'b0, exc = 1'b0, halt = 1'b0;
  logic        br = 1'b0, jmp = 1'b0;
  logic [31:0] br_tgt = '0, jmp_tgt = '0;
  logic        pause, we, flush_if, flush_id, halted;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .EXC_VECTOR(EXC_VEC)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .i_FetchCtrl_stall      (stall),
    .i_FetchCtrl_freeze     (freeze),
    .i_FetchCtrl_exc        (exc),
    .i_FetchCtrl_halt       (halt),
    .i_FetchCtrl_br_taken   (br),
    .i_FetchCtrl_br_target  (br_tgt),
    .i_FetchCtrl_jmp        (jmp),
    .i_FetchCtrl_jmp_target (jmp_tgt),
    .o_FetchCtrl_pause      (pause),
    .o_FetchCtrl_we         (we),
    .o_FetchCtrl_PC         (pc),
    .o_FetchCtrl_flush_if   (flush_if),
    .o_FetchCtrl_flush_id   (flush_id),
    .o_FetchCtrl_halted     (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch PC as the fetch stage would see it, built from DUT outputs.
  logic [31:0] dut_fpc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) dut_fpc <= '0;
    else if (!pause) dut_fpc <= we ? pc : dut_fpc + 32'd4;
  end

  // Behavioural model: mode 0=booting, 1=running, 2=halted; optional pending request.
  int          m_mode = 0, m_boot_seen = 0;
  bit          m_pend_v = 0;
  int          m_pend_p = 0;
  logic [31:0] m_pend_t = '0, m_fpc = '0;
  int          n_mode, n_boot_seen, n_pend_p;
  bit          n_pend_v;
  logic [31:0] n_pend_t, n_fpc;
  int          boot_len;
  assign boot_len = (BOOT_CYCLES == 0) ? 1 : int'(BOOT_CYCLES);

  always @(negedge clk) begin
    logic e_pause, e_we, e_fi, e_fd, e_halted;
    logic [31:0] e_pc, r_t, a_t;
    int r_p, a_p;
    e_pause = 1; e_we = 0; e_pc = '0; e_fi = 0; e_fd = 0; e_halted = 0;
    n_mode = m_mode; n_boot_seen = m_boot_seen; n_pend_v = m_pend_v;
    n_pend_p = m_pend_p; n_pend_t = m_pend_t;
    r_p = 0; r_t = '0;
    if (exc) begin r_p = 4; r_t = EXC_VEC; end
    else if (halt) r_p = 3;
    else if (br) begin r_p = 2; r_t = br_tgt; end
    else if (jmp && !stall) begin r_p = 1; r_t = jmp_tgt; end
    if (rstn) begin
      if (m_mode == 0) begin
        n_boot_seen = m_boot_seen + 1;
        if (n_boot_seen >= boot_len) n_mode = 1;
      end else if (m_mode == 2) begin
        e_halted = 1;
      end else if (freeze) begin
        if (r_p > (m_pend_v ? m_pend_p : 0)) begin
          n_pend_v = 1; n_pend_p = r_p; n_pend_t = r_t;
        end
      end else begin
        a_p = r_p; a_t = r_t;
        if (m_pend_v && m_pend_p >= r_p) begin a_p = m_pend_p; a_t = m_pend_t; end
        n_pend_v = 0;
        if (a_p == 4 || a_p == 2) begin
          e_pause = 0; e_we = 1; e_pc = a_t; e_fi = 1; e_fd = 1;
        end else if (a_p == 1) begin
          e_pause = 0; e_we = 1; e_pc = a_t; e_fi = 1;
        end else if (a_p == 3) begin
          e_fi = 1; n_mode = 2;
        end else begin
          e_pause = stall;
        end
      end
      chk("fetch_pc", dut_fpc, m_fpc);
    end
    chk("pause", pause, e_pause);
    chk("we", we, e_we);
    chk("pc", pc, e_pc);
    chk("flush_if", flush_if, e_fi);
    chk("flush_id", flush_id, e_fd);
    chk("halted", halted, e_halted);
    n_fpc = e_pause ? m_fpc : (e_we ? e_pc : m_fpc + 32'd4);
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_mode = 0; m_boot_seen = 0; m_pend_v = 0; m_pend_p = 0; m_pend_t = '0; m_fpc = '0;
    end else begin
      m_mode = n_mode; m_boot_seen = n_boot_seen; m_pend_v = n_pend_v;
      m_pend_p = n_pend_p; m_pend_t = n_pend_t; m_fpc = n_fpc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    chk("rst_pause", pause, 1); chk("rst_we", we, 0); chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk); chk("boot0_pause", pause, 1);
    @(negedge clk); chk("boot1_pause", pause, 1);
    @(negedge clk); chk("run_pause", pause, 0); chk("run_we", we, 0); chk("fpc0", dut_fpc, 0);
    @(negedge clk); chk("fpc4", dut_fpc, 32'h4);
    @(negedge clk); chk("fpc8", dut_fpc, 32'h8);

    step(); stall = 1; br = 1; br_tgt = 32'h40;
    @(negedge clk);
    chk("br_we", we, 1); chk("br_pc", pc, 32'h40); chk("br_fi", flush_if, 1); chk("br_fd", flush_id, 1);
    step(); stall = 0; br = 0;
    @(negedge clk); chk("br_fpc", dut_fpc, 32'h40); chk("br_once", flush_if, 0);

    step(); jmp = 1; jmp_tgt = 32'h80; stall = 1;
    @(negedge clk); chk("jst_pause", pause, 1); chk("jst_we", we, 0);
    step(); stall = 0;
    @(negedge clk);
    chk("jmp_we", we, 1); chk("jmp_pc", pc, 32'h80); chk("jmp_fi", flush_if, 1); chk("jmp_fd", flush_id, 0);
    step(); jmp = 0;

    step(); freeze = 1; jmp = 1; jmp_tgt = 32'h80;
    @(negedge clk); chk("frz1_pause", pause, 1);
    step(); jmp = 0; br = 1; br_tgt = 32'h40;
    @(negedge clk); chk("frz2_pause", pause, 1);
    step(); br = 0;
    @(negedge clk); chk("frz3_pause", pause, 1); chk("frz3_we", we, 0);
    step(); freeze = 0;
    @(negedge clk);
    chk("rel_we", we, 1); chk("rel_pc", pc, 32'h40); chk("rel_fi", flush_if, 1); chk("rel_fd", flush_id, 1);
    step();
    @(negedge clk); chk("rel_run_pause", pause, 0); chk("rel_run_we", we, 0);

    step(); exc = 1; halt = 1;
    @(negedge clk); chk("exc_pc", pc, EXC_VEC); chk("exc_we", we, 1);
    step(); exc = 0; halt = 0;
    step(); halt = 1;
    @(negedge clk); chk("halt_pause", pause, 1); chk("halt_fi", flush_if, 1); chk("halt_h0", halted, 0);
    step(); halt = 0; br = 1; br_tgt = 32'h40;
    @(negedge clk); chk("halted_h", halted, 1); chk("halted_we", we, 0);
    repeat (3) step();
    @(negedge clk); chk("halted_stay", halted, 1); chk("halted_pause", pause, 1);
    @(posedge clk); #2 rstn = 0; #1;
    chk("mid_rst_halted", halted, 0); chk("mid_rst_pause", pause, 1); chk("mid_rst_we", we, 0);
    br = 0;

    for (int c = 0; c < 3000; c++) begin
      step();
      rstn    = ($urandom_range(0, 59) != 0);
      freeze  = ($urandom_range(0, 3) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      exc     = ($urandom_range(0, 29) == 0);
      halt    = ($urandom_range(0, 79) == 0);
      br      = ($urandom_range(0, 5) == 0);
      jmp     = ($urandom_range(0, 4) == 0);
      br_tgt  = $urandom() & 32'hFFFF_FFFC;
      jmp_tgt = $urandom() & 32'hFFFF_FFFC;
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
